// File: rtl/writeback_arbiter_pkg.sv
// Shared widths, the queue entry type and a register one-hot helper
// used by the writeback arbiter and its result queue.
package writeback_arbiter_pkg;

   localparam int DATA_W     = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;
   localparam int CNT_W      = 5;

   typedef struct packed {
      logic                  live;
      logic [REG_ADDR_W-1:0] rd;
      logic [DATA_W-1:0]     data;
   } wb_entry_t;

   function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
      return NUM_REGS'(1) << rd;
   endfunction

endpackage

// File: rtl/wb_queue.sv
// FIFO of multi-cycle results with per-entry kill by destination register.
// The next-state live/rd view is exported so the owner can register a pending mask.
module wb_queue
   import writeback_arbiter_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             push_i,
   input  logic [REG_ADDR_W-1:0]            push_rd_i,
   input  logic [DATA_W-1:0]                push_data_i,
   input  logic                             pop_i,
   input  logic                             kill_i,
   input  logic [REG_ADDR_W-1:0]            kill_rd_i,
   output wb_entry_t                        head_o,
   output logic                             empty_o,
   output logic [CNT_W-1:0]                 count_o,
   output logic [DEPTH-1:0]                 live_nxt_o,
   output logic [DEPTH-1:0][REG_ADDR_W-1:0] rd_nxt_o
);

   // DEPTH is a power of two, so pointer increments wrap modulo DEPTH for free.
   localparam int               PTR_W     = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

   logic [PTR_W-1:0]                 wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]                 rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]                 count_q, count_d;
   logic [DEPTH-1:0]                 live_q, live_d;
   logic [DEPTH-1:0][REG_ADDR_W-1:0] rd_q, rd_d;
   logic [DATA_W-1:0]                data_q [DEPTH];
   logic                             full;
   logic                             push_ok;
   logic                             pop_ok;

   assign empty_o    = (count_q == '0);
   assign full       = (count_q == DEPTH_CNT);
   assign push_ok    = push_i && !full;
   assign pop_ok     = pop_i && !empty_o;
   assign count_o    = count_q;
   assign live_nxt_o = live_d;
   assign rd_nxt_o   = rd_d;
   assign head_o     = '{live: live_q[rd_ptr_q], rd: rd_q[rd_ptr_q], data: data_q[rd_ptr_q]};

   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      live_d   = live_q;
      rd_d     = rd_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      // Kill sees only entries already queued; the push below lands afterwards and stays live.
      if (kill_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (rd_q[i] == kill_rd_i) live_d[i] = 1'b0;
         end
      end
      if (pop_ok) begin
         live_d[rd_ptr_q] = 1'b0;
         rd_ptr_d         = rd_ptr_q + PTR_W'(1);
      end
      if (push_ok) begin
         live_d[wr_ptr_q] = 1'b1;
         rd_d[wr_ptr_q]   = push_rd_i;
         wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         live_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         live_q   <= live_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: payload storage is not reset; live_q and count_q decide whether a slot means anything.
   always_ff @(posedge clk) begin
      rd_q <= rd_d;
      if (push_ok) data_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file write port shared by the unstallable ALU and a queued multi-cycle unit;
// the ALU always wins and kills older queued results to the same register.
module writeback_arbiter
   import writeback_arbiter_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  alu_we,
   input  logic [REG_ADDR_W-1:0] alu_rd,
   input  logic [DATA_W-1:0]     alu_data,
   input  logic                  mc_valid,
   input  logic [REG_ADDR_W-1:0] mc_rd,
   input  logic [DATA_W-1:0]     mc_data,
   output logic                  mc_ready,
   output logic                  rf_we,
   output logic [REG_ADDR_W-1:0] rf_wr,
   output logic [DATA_W-1:0]     rf_wd,
   output logic [NUM_REGS-1:0]   pending,
   output logic [CNT_W-1:0]      q_count
);

   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

   wb_entry_t                        head;
   logic                             q_empty;
   logic [DEPTH-1:0]                 live_nxt;
   logic [DEPTH-1:0][REG_ADDR_W-1:0] rd_nxt;
   logic                             alu_sel;
   logic                             q_sel;
   logic                             enq;

   logic                  rf_we_q, rf_we_d;
   logic [REG_ADDR_W-1:0] rf_wr_q, rf_wr_d;
   logic [DATA_W-1:0]     rf_wd_q, rf_wd_d;
   logic [NUM_REGS-1:0]   pending_q, pending_d;

   assign mc_ready = rst && (q_count < DEPTH_CNT);
   assign alu_sel  = alu_we && (alu_rd != '0);
   assign q_sel    = !alu_sel && !q_empty;
   // Writes to r0 are accepted so the producer never blocks, then dropped.
   assign enq      = mc_valid && mc_ready && (mc_rd != '0);

   wb_queue #(
      .DEPTH(DEPTH)
   ) u_queue (
      .clk         (clk),
      .rst         (rst),
      .push_i      (enq),
      .push_rd_i   (mc_rd),
      .push_data_i (mc_data),
      .pop_i       (q_sel),
      .kill_i      (alu_sel),
      .kill_rd_i   (alu_rd),
      .head_o      (head),
      .empty_o     (q_empty),
      .count_o     (q_count),
      .live_nxt_o  (live_nxt),
      .rd_nxt_o    (rd_nxt)
   );

   always_comb begin
      rf_we_d = alu_sel || (q_sel && head.live);
      rf_wr_d = rf_wr_q;
      rf_wd_d = rf_wd_q;
      if (alu_sel) begin
         rf_wr_d = alu_rd;
         rf_wd_d = alu_data;
      end else if (q_sel && head.live) begin
         rf_wr_d = head.rd;
         rf_wd_d = head.data;
      end
   end

   // Built from the queue's next state so the mask moves on the same edge as the entries.
   always_comb begin
      pending_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (live_nxt[i]) pending_d = pending_d | rd_onehot(rd_nxt[i]);
      end
      pending_d[0] = 1'b0;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rf_we_q   <= 1'b0;
         rf_wr_q   <= '0;
         rf_wd_q   <= '0;
         pending_q <= '0;
      end else begin
         rf_we_q   <= rf_we_d;
         rf_wr_q   <= rf_wr_d;
         rf_wd_q   <= rf_wd_d;
         pending_q <= pending_d;
      end
   end

   assign rf_we   = rf_we_q;
   assign rf_wr   = rf_wr_q;
   assign rf_wd   = rf_wd_q;
   assign pending = pending_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: stimulus pushes expected writes (with their
// due cycle) into a scoreboard; a negedge monitor pops and compares every rf write.
module tb_writeback_arbiter;
   import writeback_arbiter_pkg::*;

   localparam int DEPTH = 4;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  alu_we;
   logic [REG_ADDR_W-1:0] alu_rd;
   logic [DATA_W-1:0]     alu_data;
   logic                  mc_valid;
   logic [REG_ADDR_W-1:0] mc_rd;
   logic [DATA_W-1:0]     mc_data;
   logic                  mc_ready;
   logic                  rf_we;
   logic [REG_ADDR_W-1:0] rf_wr;
   logic [DATA_W-1:0]     rf_wd;
   logic [NUM_REGS-1:0]   pending;
   logic [CNT_W-1:0]      q_count;

   typedef struct {
      logic [REG_ADDR_W-1:0] rd;
      logic [DATA_W-1:0]     data;
      int                    cyc;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   writeback_arbiter #(.DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .alu_we   (alu_we),
      .alu_rd   (alu_rd),
      .alu_data (alu_data),
      .mc_valid (mc_valid),
      .mc_rd    (mc_rd),
      .mc_data  (mc_data),
      .mc_ready (mc_ready),
      .rf_we    (rf_we),
      .rf_wr    (rf_wr),
      .rf_wd    (rf_wd),
      .pending  (pending),
      .q_count  (q_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data, input int offset);
      exp_t e;
      e.rd   = rd;
      e.data = data;
      e.cyc  = cyc + offset;
      sb.push_back(e);
   endtask

   task automatic drive(input logic a_we, input logic [4:0] a_rd, input logic [31:0] a_d,
                        input logic m_v, input logic [4:0] m_rd, input logic [31:0] m_d);
      alu_we   = a_we;
      alu_rd   = a_rd;
      alu_data = a_d;
      mc_valid = m_v;
      mc_rd    = m_rd;
      mc_data  = m_d;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
   endtask

   task automatic tick(input int n = 1);
      for (int k = 0; k < n; k++) @(negedge clk);
   endtask

   // Monitor: every rf write must match the oldest expectation, including its due cycle.
   always @(negedge clk) begin
      exp_t e;
      if (rf_we === 1'b1) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: got rd=%0d data=0x%0h at cycle %0d, expected no write",
                     rf_wr, rf_wd, cyc);
         end else begin
            e = sb.pop_front();
            check("wr_rd", 32'(rf_wr), 32'(e.rd));
            check("wr_data", rf_wd, e.data);
            check("wr_cycle", cyc, e.cyc);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int acc;
      rst = 1'b0;
      idle();
      tick(3);

      // Reset state
      check("reset_rf_we", 32'(rf_we), 32'h0);
      check("reset_rf_wr", 32'(rf_wr), 32'h0);
      check("reset_rf_wd", rf_wd, 32'h0);
      check("reset_q_count", 32'(q_count), 32'h0);
      check("reset_pending", pending, 32'h0);
      check("reset_mc_ready", 32'(mc_ready), 32'h0);
      rst = 1'b1;
      #1;
      check("post_reset_mc_ready", 32'(mc_ready), 32'h1);
      tick();

      // Single mc write r5, no ALU activity
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hAAAA);
      check("t1_mc_ready", 32'(mc_ready), 32'h1);
      expect_wr(5'd5, 32'hAAAA, 2);
      tick();
      idle();
      check("t1_pending_set", pending, 32'h0000_0020);
      check("t1_q_count_1", 32'(q_count), 32'h1);
      tick();
      check("t1_pending_clr", pending, 32'h0);
      check("t1_q_count_0", 32'(q_count), 32'h0);
      tick(2);

      // ALU r3 and mc r4 in the same cycle
      drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
      expect_wr(5'd3, 32'h11, 1);
      expect_wr(5'd4, 32'h22, 2);
      tick();
      idle();
      tick(3);

      // Enqueue and pop in the same cycle keeps the count
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hC1);
      expect_wr(5'd12, 32'hC1, 2);
      tick();
      check("t_ep_pending_a", pending, 32'h0000_1000);
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd13, 32'hC2);
      expect_wr(5'd13, 32'hC2, 2);
      tick();
      idle();
      check("t_ep_q_count", 32'(q_count), 32'h1);
      check("t_ep_pending_b", pending, 32'h0000_2000);
      tick();
      check("t_ep_q_count_0", 32'(q_count), 32'h0);
      tick(2);

      // Queued r7 killed by a later ALU write to r7
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h1);
      tick();
      check("t3_pending_set", pending, 32'h0000_0080);
      drive(1'b1, 5'd7, 32'h2, 1'b0, 5'd0, 32'h0);
      expect_wr(5'd7, 32'h2, 1);
      tick();
      idle();
      check("t3_pending_clr", pending, 32'h0);
      check("t3_q_count_killed", 32'(q_count), 32'h1);
      tick();
      check("t3_killed_pop_no_we", 32'(rf_we), 32'h0);
      check("t3_q_count_0", 32'(q_count), 32'h0);
      tick(2);

      // Same-cycle enqueue to the killed register stays live
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h91);
      tick();
      drive(1'b1, 5'd9, 32'h92, 1'b1, 5'd9, 32'h93);
      expect_wr(5'd9, 32'h92, 1);
      tick();
      idle();
      check("t_ks_q_count_2", 32'(q_count), 32'h2);
      check("t_ks_pending", pending, 32'h0000_0200);
      tick();
      check("t_ks_killed_no_we", 32'(rf_we), 32'h0);
      check("t_ks_q_count_1", 32'(q_count), 32'h1);
      expect_wr(5'd9, 32'h93, 1);
      tick();
      check("t_ks_q_count_0", 32'(q_count), 32'h0);
      check("t_ks_pending_clr", pending, 32'h0);
      tick(2);

      // Sustained ALU writes starve the queue; mc_ready drops after DEPTH acceptances
      acc = 0;
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 5'd1, 32'h1000 + i, 1'b1, 5'(10 + acc), 32'h100 + acc);
         check("t4_mc_ready", 32'(mc_ready), (i < 4) ? 32'h1 : 32'h0);
         expect_wr(5'd1, 32'h1000 + i, 1);
         if (i < 4) acc++;
         tick();
      end
      idle();
      check("t4_q_count_full", 32'(q_count), 32'h4);
      check("t4_pending_full", pending, 32'h0000_3C00);
      check("t4_mc_ready_full", 32'(mc_ready), 32'h0);
      for (int j = 0; j < 4; j++) expect_wr(5'(10 + j), 32'h100 + j, j + 1);
      tick(5);
      check("t4_q_count_drained", 32'(q_count), 32'h0);
      check("t4_pending_drained", pending, 32'h0);

      // Writes to r0 from both sources are dropped
      drive(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
      check("t5_mc_ready", 32'(mc_ready), 32'h1);
      tick();
      idle();
      check("t5_no_we", 32'(rf_we), 32'h0);
      check("t5_q_count", 32'(q_count), 32'h0);
      check("t5_pending", pending, 32'h0);
      tick();
      check("t5_no_we_later", 32'(rf_we), 32'h0);
      tick();

      // Reset with three queued entries drops them without writes
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 5'd2, 32'h2000 + i, 1'b1, 5'(20 + i), 32'h300 + i);
         expect_wr(5'd2, 32'h2000 + i, 1);
         tick();
      end
      idle();
      check("t6_q_count_3", 32'(q_count), 32'h3);
      check("t6_pending_3", pending, 32'h0070_0000);
      rst = 1'b0;
      tick();
      check("t6_rst_q_count", 32'(q_count), 32'h0);
      check("t6_rst_pending", pending, 32'h0);
      check("t6_rst_rf_we", 32'(rf_we), 32'h0);
      check("t6_rst_rf_wr", 32'(rf_wr), 32'h0);
      check("t6_rst_rf_wd", rf_wd, 32'h0);
      check("t6_rst_mc_ready", 32'(mc_ready), 32'h0);
      rst = 1'b1;
      #1;
      check("t6_mc_ready_after", 32'(mc_ready), 32'h1);
      tick(4);
      check("t6_q_count_after", 32'(q_count), 32'h0);

      check("sb_drained", sb.size(), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
